// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the systolic matrix-multiply array: primes SRAM reads,
// steps the array schedule and drains anti-diagonal result beats under backpressure.
module systolic_seq_ctrl #(
  parameter int ARRAY_SIZE  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DRAIN_START = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] w_raddr,
  output logic [ADDR_WIDTH-1:0] d_raddr,
  output logic                  feed_zero,
  output logic                  alu_start,
  output logic [8:0]            cycle_num,
  output logic [5:0]            matrix_index,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [8:0] C_LAST      = 9'(3*ARRAY_SIZE-1);
  localparam logic [8:0] C_READ_END  = 9'(ARRAY_SIZE-1);
  localparam logic [8:0] C_INC_END   = 9'(ARRAY_SIZE-2);
  localparam logic [8:0] C_ZERO      = 9'(ARRAY_SIZE);
  localparam logic [8:0] C_DRAIN     = 9'(DRAIN_START);
  localparam logic [8:0] C_DRAIN_END = 9'(DRAIN_START+2*ARRAY_SIZE-2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t     state, state_nxt;
  logic [8:0] c;
  logic       in_window;
  logic       stall;
  logic       advance;

  assign in_window = (state == RUN) && (c >= C_DRAIN) && (c <= C_DRAIN_END);
  assign stall     = in_window && !out_ready;
  assign advance   = (state == RUN) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     if (advance && (c == C_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    sram_rd_en   = (state == PRIME) || ((state == RUN) && (c < C_READ_END));
    feed_zero    = (state == RUN) && (c >= C_ZERO);
    out_valid    = in_window;
    alu_start    = advance;
    cycle_num    = c;
    matrix_index = in_window ? 6'(c - C_DRAIN) : '0;
  end

  // Addresses are loaded with the bases on accept and pre-incremented in PRIME,
  // so RUN cycle c always presents base+c+1 without a separate adder per port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c       <= '0;
      w_raddr <= '0;
      d_raddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          c <= '0;
          if (start) begin
            w_raddr <= w_base;
            d_raddr <= d_base;
          end
        end
        PRIME: begin
          c       <= '0;
          w_raddr <= w_raddr + ADDR_ONE;
          d_raddr <= d_raddr + ADDR_ONE;
        end
        RUN: begin
          if (advance) begin
            c <= (c == C_LAST) ? '0 : c + 9'd1;
            if (c < C_INC_END) begin
              w_raddr <= w_raddr + ADDR_ONE;
              d_raddr <= d_raddr + ADDR_ONE;
            end
          end
        end
        default: c <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl against a job-timeline reference model.
module tb_systolic_seq_ctrl;
  localparam int N  = 32;
  localparam int AW = 10;
  localparam int DS = 33;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [AW-1:0] w_base, d_base;
  logic          busy, done, sram_rd_en, feed_zero, alu_start, out_valid;
  logic [AW-1:0] w_raddr, d_raddr;
  logic [8:0]    cycle_num;
  logic [5:0]    matrix_index;

  systolic_seq_ctrl #(.ARRAY_SIZE(N), .ADDR_WIDTH(AW), .DRAIN_START(DS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_base(w_base), .d_base(d_base),
    .busy(busy), .done(done), .sram_rd_en(sram_rd_en), .w_raddr(w_raddr),
    .d_raddr(d_raddr), .feed_zero(feed_zero), .alu_start(alu_start),
    .cycle_num(cycle_num), .matrix_index(matrix_index), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // A job is described by its age since acceptance (1 = priming cycle) and the
  // number of stalled cycles seen so far; the schedule position follows from those.
  bit m_busy = 0;
  int m_age, m_stalls, m_wb, m_db;
  int m_lw = 0, m_ld = 0;
  int m_dones = 0, dut_dones = 0, dut_beats = 0;

  function automatic int cur_c();
    return m_age - 2 - m_stalls;
  endfunction

  task automatic cycle(input logic s, input logic rdy, input logic rn,
                       input logic [AW-1:0] wb, input logic [AW-1:0] db);
    int  c;
    bit  prime, run, dn, ov, stl, rd;
    @(negedge clk);
    start = s; out_ready = rdy; rst_n = rn; w_base = wb; d_base = db;
    #1;
    c     = cur_c();
    prime = m_busy && (m_age == 1);
    run   = m_busy && (m_age >= 2) && (c <= 3*N-1);
    dn    = m_busy && (m_age >= 2) && (c == 3*N);
    ov    = run && (c >= DS) && (c <= DS + 2*N - 2);
    stl   = ov && !rdy;
    rd    = prime || (run && (c + 1 < N));
    if (prime) begin
      m_lw = m_wb; m_ld = m_db;
    end else if (rd) begin
      m_lw = (m_wb + c + 1) % (1 << AW);
      m_ld = (m_db + c + 1) % (1 << AW);
    end
    check("busy", busy, m_busy);
    check("done", done, dn);
    check("sram_rd_en", sram_rd_en, rd);
    check("w_raddr", w_raddr, m_lw);
    check("d_raddr", d_raddr, m_ld);
    check("feed_zero", feed_zero, run && (c >= N));
    check("alu_start", alu_start, run && !stl);
    check("out_valid", out_valid, ov);
    check("cycle_num", cycle_num, run ? c : 0);
    check("matrix_index", matrix_index, ov ? c - DS : 0);
    if (out_valid === 1'b1 && out_ready) dut_beats++;
    if (done === 1'b1) dut_dones++;
    if (dn) begin
      check("beats_per_job", dut_beats, 2*N - 1);
      m_dones++;
    end
    if (!rn) begin
      m_busy = 0; m_lw = 0; m_ld = 0; dut_beats = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_age = 1; m_stalls = 0; m_wb = wb; m_db = db; dut_beats = 0;
      end
    end else if (dn) begin
      m_busy = 0;
    end else begin
      if (stl) m_stalls++;
      m_age++;
    end
  endtask

  initial begin
    int  hold;
    bit  s, r, rn;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; w_base = '0; d_base = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, '0);

    // basic job
    cycle(1, 1, 1, 10'h100, 10'h200);
    for (int i = 0; i < 104; i++) cycle(0, 1, 1, 10'($urandom), 10'($urandom));

    // backpressure: 5 stalled cycles on beat 10
    hold = 0;
    cycle(1, 1, 1, 10'h055, 10'h2AA);
    for (int i = 0; i < 110; i++) begin
      r = !(m_busy && m_age >= 2 && cur_c() == DS + 10 && hold < 5);
      if (!r) hold++;
      cycle(0, r, 1, 10'($urandom), 10'($urandom));
    end

    // start pulses while busy, including in the done cycle
    cycle(1, 1, 1, 10'h010, 10'h020);
    for (int i = 0; i < 104; i++) begin
      s = m_busy && (m_age == 10 || m_age == 60 || m_age == 98);
      cycle(s, 1, 1, 10'($urandom), 10'($urandom));
    end

    // reset mid-job, then a full job
    cycle(1, 1, 1, 10'h123, 10'h321);
    for (int i = 0; i < 60; i++) begin
      rn = !(m_busy && m_age >= 2 && cur_c() == 50);
      cycle(0, 1, rn, 10'($urandom), 10'($urandom));
    end
    cycle(1, 1, 1, 10'h0C0, 10'h0D0);
    for (int i = 0; i < 104; i++) cycle(0, 1, 1, 10'($urandom), 10'($urandom));

    // address wrap
    cycle(1, 1, 1, 10'h3F0, 10'h3F8);
    for (int i = 0; i < 104; i++) cycle(0, 1, 1, 10'($urandom), 10'($urandom));

    // back-to-back with start held high
    for (int i = 0; i < 205; i++) cycle(1, 1, 1, 10'($urandom), 10'($urandom));
    for (int i = 0; i < 100; i++) cycle(0, 1, 1, 10'($urandom), 10'($urandom));

    // random traffic with random backpressure and rare resets
    for (int i = 0; i < 2500; i++) begin
      s  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 399) != 0);
      cycle(s, r, rn, 10'($urandom), 10'($urandom));
    end
    for (int i = 0; i < 250; i++) cycle(0, 1, 1, '0, '0);

    check("done_count", dut_dones, m_dones);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the 32x32 weight-stationary-free systolic matrix-multiply array. It accepts a job (weight/data SRAM base addresses) through a start/busy/done handshake and issues SRAM row reads with one-cycle-ahead prefetch. It drives the array's alu_start, cycle_num and matrix_index, then streams the 2*ARRAY_SIZE-1 anti-diagonal result beats to write-back under valid/ready backpressure. When write-back stalls, it freezes the array.

Parameters:
ARRAY_SIZE, 32, array dimension; rows fed per job.
ADDR_WIDTH, 10, SRAM row address width.
DRAIN_START, 33, cycle_num of first valid result diagonal (must be > ARRAY_SIZE).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  job request; accepted only in IDLE
w_base  in  ADDR_WIDTH  weight SRAM base row, sampled on accept
d_base  in  ADDR_WIDTH  data SRAM base row, sampled on accept
busy  out  1  high from accept until DONE inclusive
done  out  1  one-cycle pulse in DONE
sram_rd_en  out  1  SRAM read enable (read data valid next cycle)
w_raddr  out  ADDR_WIDTH  weight row address
d_raddr  out  ADDR_WIDTH  data row address
feed_zero  out  1  array input mux selects zeros instead of SRAM data
alu_start  out  1  array advance/accumulate enable
cycle_num  out  9  array schedule counter
matrix_index  out  6  diagonal selected on array output
out_valid  out  1  result beat on array output is valid
out_ready  in  1  write-back accepts beat

Behaviour:
- Reset (rst_n=0 at posedge) applies in any state, including mid-job. It forces IDLE; busy, done, sram_rd_en, feed_zero, alu_start and out_valid are 0; cycle_num, matrix_index, w_raddr and d_raddr are 0. Any in-flight job is discarded.
- All outputs are registered or decoded from state and counters only. There is no combinational path from start or out_ready to any output except alu_start (see stall rule below).
- States: IDLE -> PRIME -> RUN -> DONE -> IDLE.
- IDLE: when start=1, latch w_base/d_base and go to PRIME. start is ignored in every other state.
- PRIME (1 cycle):
  - sram_rd_en=1, w_raddr=w_base, d_raddr=d_base.
  - alu_start=0, cycle_num=0.
- RUN, counter c = cycle_num, running 0..3*ARRAY_SIZE-1 (0..95):
  - alu_start=1 unless stalled.
  - Prefetch: sram_rd_en=1 with addr=base+c+1 while c+1 < ARRAY_SIZE (c=0..30); otherwise sram_rd_en=0 and addresses hold their last value.
  - feed_zero=1 when c >= ARRAY_SIZE, else 0.
  - Output window: out_valid=1 when DRAIN_START <= c <= DRAIN_START+2*ARRAY_SIZE-2 (33..95); matrix_index = c-DRAIN_START (0..62) in that window, else 0.
  - c advances by 1 on each cycle where not stalled.
  - Transition to DONE on the cycle where c=95 advances (i.e. beat accepted).
- Stall: out_valid=1 and out_ready=0 means stalled.
  - alu_start=0; cycle_num and matrix_index hold.
  - out_valid stays 1 with the same matrix_index until accepted.
  - Stalls cannot occur while reads are outstanding, because DRAIN_START > ARRAY_SIZE. No SRAM hold logic is needed.
- DONE: done=1, busy=1 for one cycle; alu_start=0, out_valid=0; then IDLE. A start in DONE is ignored.
- Timing with no stall: accept at edge T0 -> PRIME in cycle 1 -> RUN in cycles 2..97 -> DONE in cycle 98 -> idle in cycle 99. Latency from start to done is 98 cycles plus total stall cycles.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; base+31 overflowing wraps without any error flag.
- out_ready is ignored whenever out_valid=0.

Test Plan:
- Basic job: w_base=0x100, d_base=0x200, out_ready=1. Required response:
  - PRIME issues 0x100/0x200.
  - RUN reads 0x101..0x11F / 0x201..0x21F for c=0..30, i.e. 32 reads total.
  - feed_zero rises at c=32.
  - 63 out_valid beats with matrix_index 0..62 in cycles 35..97.
  - done pulses in cycle 98.
- Backpressure: out_ready=0 for 5 cycles at matrix_index=10 -> matrix_index stays 10, cycle_num stays 43, alu_start=0 for those 5 cycles. done arrives at cycle 103; beat sequence is unchanged.
- Start during busy: start pulsed at cycles 10, 60 and 98 -> ignored; busy stays high; exactly one done; the next start is accepted only after returning to IDLE.
- Reset mid-job: rst_n=0 at cycle_num=50 -> next cycle IDLE, all outputs 0, no done pulse. A subsequent start runs a full 63-beat job.
- Address wrap: w_base=0x3F0 (ADDR_WIDTH=10) -> reads 0x3F0..0x3FF then 0x000..0x00F.
- Back-to-back: start held high continuously -> the second job is accepted in cycle 99 (first IDLE cycle); there are no beats in the gap and the second job's beats start at matrix_index 0.
